// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard link (host transmitter and the
// keyboard decoder path):
//   - ps2_state_e : host-to-device transmitter state encoding
//   - CMD_* / RSP_* : common keyboard command and response bytes
//   - BIT_*        : frame positions of the transmitter bit counter
//   - odd_parity() : parity bit that makes a data byte plus parity odd
// ---------------------------------------------------------------------------
package ps2_pkg;

  // Host-to-device transmitter states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  // Keyboard commands sent by the host
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // Keyboard acknowledge response
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  // Bit counter value held while waiting for the device clock fall that
  // places the parity bit, the stop bit, and the ACK sample respectively
  localparam logic [3:0] BIT_PARITY  = 4'd8;
  localparam logic [3:0] BIT_STOP    = 4'd9;
  localparam logic [3:0] BIT_ACK     = 4'd10;
  localparam logic [3:0] BIT_DONE    = 4'd11;

  // Odd parity: the returned bit makes the count of ones in {par, data} odd
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage : ps2_pkg

// File: rtl/ps2_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
// Two-flop synchronizer for one PS/2 pin followed by a falling-edge detector.
// Shared by the host transmitter and the keyboard decoder path.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   pin  : raw, asynchronous pin value
//   sync : synchronized pin value (2 flops of latency)
//   fall : high for one cycle when sync goes 1 -> 0
// The flops reset to 1 because an idle PS/2 line is pulled high; this keeps
// reset release from producing a spurious fall.
// fall is a plain AND of two flops so the consumer can register the edge in
// the very next cycle (pin edge to consumer register = 3 clocks).
// ---------------------------------------------------------------------------
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic sync,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain plus one cycle of history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      meta_r <= pin;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign sync = sync_r;
  assign fall = prev_r & ~sync_r;

endmodule : ps2_sync_edge

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// using the request-to-send sequence on the shared open-drain pins.
// Parameters:
//   CLK_HZ         : system clock frequency
//   INHIBIT_CYCLES : clock-low hold before the request (120 us)
//   TIMEOUT_CYCLES : longest allowed gap between device clock falls (20 ms)
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   tx_valid     : command byte on tx_data is valid
//   tx_data      : command byte
//   tx_ready     : high only when idle; byte accepted on tx_valid && tx_ready
//   tx_done      : one-cycle pulse, device acknowledged the byte
//   tx_error     : one-cycle pulse, no ACK or device clock timeout
//   busy         : transfer in progress (decoder should ignore the lines)
//   ps2_clk_in   : raw PS2_CLK pin
//   ps2_data_in  : raw PS2_DATA pin
//   ps2_clk_oe   : 1 = pull PS2_CLK low
//   ps2_data_oe  : 1 = pull PS2_DATA low
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int INHIBIT_CYCLES = (CLK_HZ / 1_000_000) * 120,
  parameter int TIMEOUT_CYCLES = (CLK_HZ / 1_000) * 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  // Last count of the inhibit hold and of the watchdog before expiry
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e       state_r;
  logic [7:0]       byte_r;
  logic             par_r;
  logic [3:0]       bit_cnt_r;
  logic [INH_W-1:0] inhibit_cnt_r;
  logic [WD_W-1:0]  wdog_r;
  logic             ack_ok_r;

  logic clk_sync_s;
  logic clk_fall_s;
  logic data_sync_s;
  logic data_fall_unused_s;
  logic wdog_run_s;
  logic wdog_expire_s;

  ps2_sync_edge u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (ps2_clk_in),
    .sync (clk_sync_s),
    .fall (clk_fall_s)
  );

  // The data line is only sampled at levels; its edge output is not needed
  ps2_sync_edge u_data_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (ps2_data_in),
    .sync (data_sync_s),
    .fall (data_fall_unused_s)
  );

  // Watchdog runs only while the device owns the clock; a fall in the
  // expiry cycle still counts as activity and wins over the timeout
  always_comb begin
    wdog_run_s    = 1'b0;
    wdog_expire_s = 1'b0;
    case (state_r)
      REQ, SHIFT, ACK, WAIT_IDLE: wdog_run_s = 1'b1;
      default:                    wdog_run_s = 1'b0;
    endcase
    if (wdog_run_s && !clk_fall_s && (wdog_r == WD_LAST)) begin
      wdog_expire_s = 1'b1;
    end else begin
      wdog_expire_s = 1'b0;
    end
  end

  // Transmit FSM with registered handshake and pin-drive outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      byte_r        <= 8'h00;
      par_r         <= 1'b0;
      bit_cnt_r     <= 4'd0;
      inhibit_cnt_r <= '0;
      wdog_r        <= '0;
      ack_ok_r      <= 1'b0;
      tx_ready      <= 1'b1;
      tx_done       <= 1'b0;
      tx_error      <= 1'b0;
      busy          <= 1'b0;
      ps2_clk_oe    <= 1'b0;
      ps2_data_oe   <= 1'b0;
    end else begin
      // Completion pulses last a single cycle unless re-asserted below
      tx_done  <= 1'b0;
      tx_error <= 1'b0;

      if (!wdog_run_s || clk_fall_s) begin
        wdog_r <= '0;
      end else begin
        wdog_r <= wdog_r + WD_W'(1);
      end

      if (wdog_expire_s) begin
        // Device went silent: let go of both lines and report failure
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        tx_error    <= 1'b1;
        tx_ready    <= 1'b1;
        busy        <= 1'b0;
        state_r     <= IDLE;
      end else begin
        case (state_r)
          IDLE: begin
            if (tx_valid && tx_ready) begin
              byte_r        <= tx_data;
              par_r         <= odd_parity(tx_data);
              bit_cnt_r     <= 4'd0;
              inhibit_cnt_r <= '0;
              ack_ok_r      <= 1'b0;
              tx_ready      <= 1'b0;
              busy          <= 1'b1;
              ps2_clk_oe    <= 1'b1;
              ps2_data_oe   <= 1'b0;
              state_r       <= INHIBIT;
            end
          end

          INHIBIT: begin
            // Clock held low; at the end assert the start bit while the
            // clock is still held so the device sees data low first
            if (inhibit_cnt_r == INH_LAST) begin
              ps2_data_oe <= 1'b1;
              state_r     <= REQ;
            end else begin
              inhibit_cnt_r <= inhibit_cnt_r + INH_W'(1);
            end
          end

          REQ: begin
            // First cycle here releases the clock; the device then starts
            // clocking and its first fall places data bit 0
            ps2_clk_oe <= 1'b0;
            if (clk_fall_s) begin
              ps2_data_oe <= ~byte_r[0];
              bit_cnt_r   <= 4'd1;
              state_r     <= SHIFT;
            end
          end

          SHIFT: begin
            if (clk_fall_s) begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r < BIT_PARITY) begin
                ps2_data_oe <= ~byte_r[bit_cnt_r[2:0]];
              end else if (bit_cnt_r == BIT_PARITY) begin
                ps2_data_oe <= ~par_r;
              end else begin
                // Stop bit is a released (high) line
                ps2_data_oe <= 1'b0;
                state_r     <= ACK;
              end
            end
          end

          ACK: begin
            // Device pulls data low across this fall to acknowledge
            if (clk_fall_s) begin
              ack_ok_r  <= ~data_sync_s;
              bit_cnt_r <= BIT_DONE;
              state_r   <= WAIT_IDLE;
            end
          end

          WAIT_IDLE: begin
            if (clk_sync_s && data_sync_s) begin
              tx_done  <= ack_ok_r;
              tx_error <= ~ack_ok_r;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              state_r  <= IDLE;
            end
          end

          default: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule : ps2_host_tx

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Self-checking bench for ps2_host_tx. A behavioural keyboard model answers
// the request-to-send sequence on wired-AND pin models. Expected frames and
// completion results are queued when a byte is offered and popped when the
// device model has collected the frame / the DUT reports completion.
// The DUT runs at a scaled CLK_HZ so inhibit and timeout stay short.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int TB_CLK_HZ = 1_000_000;
  localparam int INH       = 120;      // 120 us at 1 MHz
  localparam int TMO       = 20_000;   // 20 ms at 1 MHz
  localparam int HALF      = 40;       // 12.5 kHz device clock half period

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       busy;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       dev_clk;
  logic       dev_data;
  logic       ps2_clk_line;
  logic       ps2_data_line;

  // Open-drain pins: low if either side pulls
  assign ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_line = dev_data & ~ps2_data_oe;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] frame_q[$];
  logic [1:0] res_q[$];   // {error, done}

  ps2_host_tx #(.CLK_HZ(TB_CLK_HZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .busy       (busy),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Parity bit that makes the number of ones odd, by counting
  function automatic logic ref_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // One transfer: offer byte b, play the device for stop_after falls,
  // optionally inject a competing tx_valid or a mid-shift reset.
  task automatic run_xfer(input logic [7:0] b, input logic ack, input int stop_after,
                          input logic inject, input logic do_rst);
    logic [9:0] obs;
    logic [9:0] expf;
    logic [9:0] mask;
    logic [1:0] expr;
    int cnt;
    int g;
    int bound;
    int seen;
    obs  = 10'd0;
    mask = 10'd0;
    frame_q.push_back({1'b1, ref_parity(b), b});
    if (!do_rst) res_q.push_back((stop_after == 11 && ack) ? 2'b01 : 2'b10);

    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check_eq("accept_busy", busy, 1);
    check_eq("accept_clk_oe", ps2_clk_oe, 1);
    check_eq("accept_ready", tx_ready, 0);

    cnt = 0;
    while (ps2_clk_oe && !ps2_data_oe && cnt < INH + 50) begin
      cnt++;
      if (inject && cnt == 10) begin
        check_eq("ready_while_busy", tx_ready, 0);
        tx_data  = CMD_ENABLE;
        tx_valid = 1'b1;
      end
      if (inject && cnt == 11) begin
        tx_valid = 1'b0;
        tx_data  = b;
      end
      @(negedge clk);
    end
    check_eq("inhibit_len", cnt, INH);
    check_eq("start_data_oe", ps2_data_oe, 1);
    check_eq("start_clk_held", ps2_clk_oe, 1);
    @(negedge clk);
    check_eq("clk_release", ps2_clk_oe, 0);
    repeat (HALF) @(negedge clk);

    for (int n = 1; n <= stop_after; n++) begin
      dev_clk = 1'b0;
      if (do_rst && n == 5) begin
        repeat (HALF / 2) @(negedge clk);
        check_eq("pre_rst_data_oe", ps2_data_oe, 1);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_clk_oe", ps2_clk_oe, 0);
        check_eq("rst_data_oe", ps2_data_oe, 0);
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        void'(frame_q.pop_front());
        seen = 0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (tx_done || tx_error) seen++;
        end
        check_eq("rst_no_pulse", seen, 0);
        check_eq("rst_ready", tx_ready, 1);
        check_eq("rst_busy", busy, 0);
        return;
      end
      repeat (HALF) @(negedge clk);
      if (n <= 10) begin
        obs[n-1] = ps2_data_line;
        mask[n-1] = 1'b1;
      end
      dev_clk = 1'b1;
      if (n == 10 && ack) dev_data = 1'b0;
      if (n == 11) dev_data = 1'b1;
      if (n < stop_after) repeat (HALF) @(negedge clk);
    end

    expf = frame_q.pop_front();
    if (stop_after >= 10) begin
      check_eq("frame", obs, expf);
      check_eq("parity_bit", obs[8], expf[8]);
    end else begin
      check_eq("partial_frame", obs & mask, expf & mask);
    end

    bound = (stop_after == 11) ? 200 : TMO + 500;
    g = 0;
    while (!(tx_done || tx_error) && g < bound) begin
      @(negedge clk);
      g++;
    end
    check_eq("pulse_seen", tx_done | tx_error, 1);
    expr = res_q.pop_front();
    check_eq("result", {tx_error, tx_done}, expr);
    check_eq("ready_at_pulse", tx_ready, 1);
    check_eq("busy_at_pulse", busy, 0);
    if (stop_after < 11) begin
      check_eq("tmo_window", (g > TMO - 100) && (g < TMO), 1);
      check_eq("tmo_clk_oe", ps2_clk_oe, 0);
      check_eq("tmo_data_oe", ps2_data_oe, 0);
    end
    @(negedge clk);
    check_eq("pulse_width", {tx_error, tx_done}, 0);
    if (inject) begin
      repeat (20) @(negedge clk);
      check_eq("no_queue_busy", busy, 0);
      check_eq("no_queue_clk_oe", ps2_clk_oe, 0);
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_ready", tx_ready, 1);
    check_eq("rst_tx_done", tx_done, 0);
    check_eq("rst_tx_error", tx_error, 0);
    check_eq("rst_busy_init", busy, 0);
    check_eq("rst_clk_oe_init", ps2_clk_oe, 0);
    check_eq("rst_data_oe_init", ps2_data_oe, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_xfer(CMD_SET_LED, 1'b1, 11, 1'b0, 1'b0);
    run_xfer(8'h07,       1'b1, 11, 1'b0, 1'b0);
    run_xfer(8'h00,       1'b1, 11, 1'b0, 1'b0);
    run_xfer(CMD_ENABLE,  1'b0, 11, 1'b0, 1'b0);  // no ACK
    run_xfer(8'hA5,       1'b1, 4,  1'b0, 1'b0);  // device stops after fall 4
    run_xfer(CMD_RESET,   1'b1, 11, 1'b1, 1'b0);  // competing tx_valid ignored
    run_xfer(8'h00,       1'b1, 11, 1'b0, 1'b1);  // reset during SHIFT
    run_xfer(CMD_ENABLE,  1'b1, 11, 1'b0, 1'b0);  // clean transfer after reset

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ps2_host_tx

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It serializes one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) onto the shared keyboard PS2_CLK/PS2_DATA lines using the PS/2 request-to-send sequence. It is the opposite direction of the existing keyboard decoder path and shares the same open-drain pins. The top level drives the pins low only when an `_oe` output is set and leaves them high-impedance otherwise. `busy` tells the decoder to ignore line activity while a transmission is in progress.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- INHIBIT_CYCLES, 12_000, clock-low hold before request (120 µs at 100 MHz)
- TIMEOUT_CYCLES, 2_000_000, maximum gap between device clock edges (20 ms)
- clk  in  1  system clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- tx_valid  in  1  command byte is valid
- tx_data  in  8  command byte
- tx_ready  out  1  high only in IDLE; transfer is accepted on tx_valid && tx_ready
- tx_done  out  1  one-cycle pulse when the device acknowledged the byte
- tx_error  out  1  one-cycle pulse on missing ACK or timeout
- busy  out  1  high from accept until return to IDLE
- ps2_clk_in  in  1  raw PS2_CLK pin value
- ps2_data_in  in  1  raw PS2_DATA pin value
- ps2_clk_oe  out  1  1 = pull PS2_CLK low
- ps2_data_oe  out  1  1 = pull PS2_DATA low

## Operation
- Both pin inputs pass through a 2-flop synchronizer. A falling edge on the device clock (`fall`) is detected as synced-previous = 1 and synced-current = 0.
- States and transitions:
  - **IDLE → INHIBIT** on accept. Latch the byte and compute odd parity: `par = ~^tx_data`.
  - **INHIBIT:** `ps2_clk_oe` = 1 for INHIBIT_CYCLES.
  - **→ REQ:** set `ps2_data_oe` = 1 (start bit), then release `ps2_clk_oe` one cycle later.
  - **REQ → SHIFT** on the 1st `fall`.
  - **SHIFT:** on `fall` n (n = 1..8), drive data bit n-1, LSB first. Drive `ps2_data_oe = ~bit`.
  - On `fall` 9, drive `par`.
  - On `fall` 10, release `ps2_data_oe` (stop bit), then go to ACK.
  - **ACK:** on `fall` 11, sample synced data. Data = 0 means the device acknowledged; data = 1 means no ACK.
  - **→ WAIT_IDLE:** wait until both synced lines are 1, then go to IDLE.
  - On return to IDLE, pulse `tx_done` (ACK received) or `tx_error` (no ACK).
- Timeout: the watchdog counter clears on every `fall` and runs in REQ, SHIFT, ACK and WAIT_IDLE. On reaching TIMEOUT_CYCLES:
  - release both lines;
  - pulse `tx_error`;
  - go to IDLE.
- `tx_valid` while busy is ignored; there is no queue.
- Bit counter is 4 bits and counts 0..11; it never wraps.

## Timing
- Reset values: `tx_ready` = 1; `tx_done`, `tx_error`, `busy`, `ps2_clk_oe`, `ps2_data_oe` = 0; state = IDLE. All outputs are registered.
- Reset asserted mid-transfer releases both lines asynchronously. The byte is dropped and no pulse is emitted.
- Accept at cycle t: `busy` and `ps2_clk_oe` are 1 at t+1, and `tx_ready` is 0 at t+1.
- `ps2_data_oe` rises at t+1+INHIBIT_CYCLES; `ps2_clk_oe` falls one cycle after that.
- Pin falling edge to data output change: 3 clk cycles (2 synchronizer + 1 register). This is well inside the device's ≥5 µs low phase.
- `tx_done` / `tx_error` go high for exactly one cycle, the same cycle `tx_ready` returns to 1.
- A new accept is possible in the cycle after the done/error pulse.

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE);
  - PS/2 command constants: CMD_SET_LED 8'hED, CMD_ENABLE 8'hF4, CMD_RESET 8'hFF, RSP_ACK 8'hFA.
- One sub-module, `ps2_sync_edge`: 2-flop synchronizer plus falling-edge detector. It is reused by the decoder path.

## Test plan
- **Send 0xED.** The device model clocks at 12.5 kHz and ACKs. Required response:
  - data line on falls 1..10 reads 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - `tx_done` pulses once;
  - `ps2_clk_oe` was held exactly 12_000 cycles.
- **Send 0x07:** parity bit = 0. **Send 0x00:** parity bit = 1. In both cases `tx_done` pulses.
- **Device holds data high on fall 11 (no ACK):** `tx_error` pulses, `tx_done` stays 0, state returns to IDLE.
- **Device stops clocking after fall 4:** after 2_000_000 cycles, `tx_error` pulses and both `_oe` outputs are 0.
- **`tx_valid` pulsed with 0xF4 during a transfer of 0xFF:** only 0xFF is transmitted, `tx_ready` stays 0 until the pulse.
- **`rst` asserted during SHIFT:** both `_oe` outputs drop before the next clk edge. After release, a 0xF4 transfer completes with `tx_done`.
